// File: rtl/pb_conditioner.sv
// N-channel push-button conditioner: 2-FF synchroniser, counter debounce,
// press/release pulses, long-press detection and optional auto-repeat per channel.
module pb_conditioner #(
  parameter int N             = 4,
  parameter int DB_CYCLES     = 16,
  parameter int LONG_CYCLES   = 1024,
  parameter int REPEAT_CYCLES = 256
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [N-1:0] pb_in_i,
  input  logic [N-1:0] repeat_en_i,
  output logic [N-1:0] level_o,
  output logic [N-1:0] press_o,
  output logic [N-1:0] release_o,
  output logic [N-1:0] long_press_o,
  output logic [N-1:0] repeat_o,
  output logic         any_press_o
);
  localparam int DBW = $clog2(DB_CYCLES) + 1;
  localparam int HCW = $clog2(LONG_CYCLES);
  localparam int RCW = $clog2(REPEAT_CYCLES) + 1;
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);
  localparam logic [HCW-1:0] HC_LAST = HCW'(LONG_CYCLES - 1);
  localparam logic [RCW-1:0] RC_LAST = RCW'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, HELD, LONG} hold_e;

  logic [N-1:0] press_ev;
  logic         any_press_q;

  for (genvar g = 0; g < N; g++) begin : g_ch
    logic           s1_q, s2_q;
    logic           level_q, level_d;
    logic [DBW-1:0] dbc_q, dbc_d;
    hold_e          state_q, state_d;
    logic [HCW-1:0] hc_q, hc_d;
    logic [RCW-1:0] rc_q, rc_d;
    logic           press_d, release_d, long_d, repeat_d;
    logic           press_q, release_q, long_q, repeat_q;

    always_comb begin
      level_d   = level_q;
      dbc_d     = dbc_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      if (s2_q == level_q) begin
        dbc_d = '0;
      end else if (dbc_q != DB_LAST) begin
        dbc_d = dbc_q + 1'b1;
      end else begin
        level_d   = s2_q;
        dbc_d     = '0;
        press_d   = s2_q;
        release_d = ~s2_q;
      end
    end

    // A release accepted this cycle wins over a pending long_press/repeat.
    always_comb begin
      state_d  = state_q;
      hc_d     = hc_q;
      rc_d     = rc_q;
      long_d   = 1'b0;
      repeat_d = 1'b0;
      case (state_q)
        IDLE: begin
          if (press_d) begin
            state_d = HELD;
            hc_d    = '0;
          end
        end
        HELD: begin
          if (release_d) begin
            state_d = IDLE;
            hc_d    = '0;
            rc_d    = '0;
          end else if (hc_q == HC_LAST) begin
            long_d  = 1'b1;
            state_d = LONG;
            rc_d    = '0;
          end else begin
            hc_d = hc_q + 1'b1;
          end
        end
        LONG: begin
          if (release_d) begin
            state_d = IDLE;
            hc_d    = '0;
            rc_d    = '0;
          end else if (rc_q == RC_LAST) begin
            rc_d     = '0;
            repeat_d = repeat_en_i[g];
          end else begin
            rc_d = rc_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        s1_q      <= 1'b0;
        s2_q      <= 1'b0;
        level_q   <= 1'b0;
        dbc_q     <= '0;
        state_q   <= IDLE;
        hc_q      <= '0;
        rc_q      <= '0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
        repeat_q  <= 1'b0;
      end else begin
        s1_q      <= pb_in_i[g];
        s2_q      <= s1_q;
        level_q   <= level_d;
        dbc_q     <= dbc_d;
        state_q   <= state_d;
        hc_q      <= hc_d;
        rc_q      <= rc_d;
        press_q   <= press_d;
        release_q <= release_d;
        long_q    <= long_d;
        repeat_q  <= repeat_d;
      end
    end

    assign press_ev[g]     = press_d;
    assign level_o[g]      = level_q;
    assign press_o[g]      = press_q;
    assign release_o[g]    = release_q;
    assign long_press_o[g] = long_q;
    assign repeat_o[g]     = repeat_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      any_press_q <= 1'b0;
    end else begin
      any_press_q <= |press_ev;
    end
  end

  assign any_press_o = any_press_q;
endmodule

// File: tb/tb_pb_conditioner.sv
// Bench for pb_conditioner: expected pulse events are queued as stimulus is
// driven and matched against pulses observed on the outputs.
module tb_pb_conditioner;
  localparam int N  = 4;
  localparam int DB = 16;
  localparam int LC = 1024;
  localparam int RC = 256;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b1;
  logic [N-1:0] pb    = '0;
  logic [N-1:0] ren   = '0;
  logic [N-1:0] level, press, rel, lp, rep;
  logic         anyp;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  int exp_q[$];
  int obs_q[$];

  pb_conditioner #(
    .N(N), .DB_CYCLES(DB), .LONG_CYCLES(LC), .REPEAT_CYCLES(RC)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .pb_in_i(pb), .repeat_en_i(ren),
    .level_o(level), .press_o(press), .release_o(rel),
    .long_press_o(lp), .repeat_o(rep), .any_press_o(anyp)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Event key: cycle*64 + channel*8 + kind (0 press, 1 release, 2 long, 3 repeat, 4 any_press)
  always @(negedge clk) begin
    for (int c = 0; c < N; c++) begin
      if (press[c] === 1'b1) obs_q.push_back(cyc*64 + c*8 + 0);
      if (rel[c]   === 1'b1) obs_q.push_back(cyc*64 + c*8 + 1);
      if (lp[c]    === 1'b1) obs_q.push_back(cyc*64 + c*8 + 2);
      if (rep[c]   === 1'b1) obs_q.push_back(cyc*64 + c*8 + 3);
    end
    if (anyp === 1'b1) obs_q.push_back(cyc*64 + 4);
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic push_ev(input int c, input int ch, input int k);
    bit found;
    exp_q.push_back(c*64 + ch*8 + k);
    if (k == 0) begin
      found = 1'b0;
      foreach (exp_q[i]) if (exp_q[i] == c*64 + 4) found = 1'b1;
      if (!found) exp_q.push_back(c*64 + 4);
    end
  endtask

  task automatic start_test();
    @(negedge clk);
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_reset();
    int t0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    pb = '1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({level, press, rel, lp, rep, anyp} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b, required all 0", {level, press, rel, lp, rep, anyp});
    end
    exp_q.delete();
    obs_q.delete();
    t0 = cyc;
    rst_n = 1'b1;
    for (int c = 0; c < N; c++) push_ev(t0 + DB + 2, c, 0);
    for (int c = 0; c < N; c++) push_ev(t0 + 2*DB + 4, c, 1);
    for (int k = 1; k <= DB + 1; k++) begin
      wait_until(t0 + k);
      vectors++;
      if (level !== '0) begin
        miscompares++;
        $display("FAIL reset_level_low: cyc+%0d level=%b, required 0000", k, level);
      end
    end
    wait_until(t0 + DB + 2);
    vectors++;
    if (level !== '1) begin
      miscompares++;
      $display("FAIL reset_level_high: level=%b, required 1111", level);
    end
    pb = '0;
    wait_until(t0 + 2*DB + 20);
    foreach (exp_q[i]) begin
      int idx = -1;
      foreach (obs_q[j]) if (idx < 0 && obs_q[j] == exp_q[i]) idx = j;
      vectors++;
      if (idx < 0) begin
        miscompares++;
        $display("FAIL reset_event: cyc=%0d ch=%0d kind=%0d got no pulse, required pulse",
                 exp_q[i]/64, (exp_q[i]/8)%8, exp_q[i]%8);
      end else obs_q.delete(idx);
    end
    vectors++;
    if (obs_q.size() != 0) begin
      miscompares++;
      $display("FAIL reset_extra: got %0d unexpected pulses (first cyc=%0d ch=%0d kind=%0d), required 0",
               obs_q.size(), obs_q[0]/64, (obs_q[0]/8)%8, obs_q[0]%8);
    end
  endtask

  task automatic test_debounce();
    int t1;
    int widths[3] = '{1, 8, 15};
    start_test();
    foreach (widths[w]) begin
      pb[0] = 1'b1;
      repeat (widths[w]) @(negedge clk);
      pb[0] = 1'b0;
      repeat (40) @(negedge clk);
    end
    vectors++;
    if (level[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL debounce_glitch_level: level[0]=%b, required 0", level[0]);
    end
    t1 = cyc;
    pb[0] = 1'b1;
    push_ev(t1 + DB + 2, 0, 0);
    push_ev(t1 + 2*DB + 2, 0, 1);
    wait_until(t1 + DB);
    pb[0] = 1'b0;
    wait_until(t1 + DB + 1);
    vectors++;
    if (level[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL debounce_early_level: level[0]=%b, required 0", level[0]);
    end
    wait_until(t1 + DB + 2);
    vectors++;
    if (level[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL debounce_accept_level: level[0]=%b, required 1", level[0]);
    end
    wait_until(t1 + 3*DB + 10);
    foreach (exp_q[i]) begin
      int idx = -1;
      foreach (obs_q[j]) if (idx < 0 && obs_q[j] == exp_q[i]) idx = j;
      vectors++;
      if (idx < 0) begin
        miscompares++;
        $display("FAIL debounce_event: cyc=%0d ch=%0d kind=%0d got no pulse, required pulse",
                 exp_q[i]/64, (exp_q[i]/8)%8, exp_q[i]%8);
      end else obs_q.delete(idx);
    end
    vectors++;
    if (obs_q.size() != 0) begin
      miscompares++;
      $display("FAIL debounce_extra: got %0d unexpected pulses (first cyc=%0d ch=%0d kind=%0d), required 0",
               obs_q.size(), obs_q[0]/64, (obs_q[0]/8)%8, obs_q[0]%8);
    end
  endtask

  task automatic test_long_repeat();
    int t, p;
    start_test();
    ren[1] = 1'b1;
    t = cyc;
    p = t + DB + 2;
    pb[1] = 1'b1;
    push_ev(p, 1, 0);
    push_ev(p + LC, 1, 2);
    for (int k = 1; k <= 3; k++) push_ev(p + LC + k*RC, 1, 3);
    push_ev(t + 2000 + DB + 2, 1, 1);
    wait_until(t + 2000);
    pb[1] = 1'b0;
    wait_until(t + 2000 + RC + 100);
    ren[1] = 1'b0;
    foreach (exp_q[i]) begin
      int idx = -1;
      foreach (obs_q[j]) if (idx < 0 && obs_q[j] == exp_q[i]) idx = j;
      vectors++;
      if (idx < 0) begin
        miscompares++;
        $display("FAIL long_repeat_event: cyc=%0d ch=%0d kind=%0d got no pulse, required pulse",
                 exp_q[i]/64, (exp_q[i]/8)%8, exp_q[i]%8);
      end else obs_q.delete(idx);
    end
    vectors++;
    if (obs_q.size() != 0) begin
      miscompares++;
      $display("FAIL long_repeat_extra: got %0d unexpected pulses (first cyc=%0d ch=%0d kind=%0d), required 0",
               obs_q.size(), obs_q[0]/64, (obs_q[0]/8)%8, obs_q[0]%8);
    end
  endtask

  task automatic test_repeat_gating();
    int t, p;
    start_test();
    ren[2] = 1'b0;
    t = cyc;
    p = t + DB + 2;
    pb[2] = 1'b1;
    push_ev(p, 2, 0);
    push_ev(p + LC, 2, 2);
    push_ev(p + LC + 2*RC, 2, 3);
    push_ev(p + LC + 3*RC, 2, 3);
    push_ev(t + 2000 + DB + 2, 2, 1);
    wait_until(p + LC + RC + 100);
    ren[2] = 1'b1;
    wait_until(t + 2000);
    pb[2] = 1'b0;
    wait_until(t + 2000 + RC + 100);
    ren[2] = 1'b0;
    foreach (exp_q[i]) begin
      int idx = -1;
      foreach (obs_q[j]) if (idx < 0 && obs_q[j] == exp_q[i]) idx = j;
      vectors++;
      if (idx < 0) begin
        miscompares++;
        $display("FAIL gating_event: cyc=%0d ch=%0d kind=%0d got no pulse, required pulse",
                 exp_q[i]/64, (exp_q[i]/8)%8, exp_q[i]%8);
      end else obs_q.delete(idx);
    end
    vectors++;
    if (obs_q.size() != 0) begin
      miscompares++;
      $display("FAIL gating_extra: got %0d unexpected pulses (first cyc=%0d ch=%0d kind=%0d), required 0",
               obs_q.size(), obs_q[0]/64, (obs_q[0]/8)%8, obs_q[0]%8);
    end
  endtask

  task automatic test_priority();
    int t, p, t2;
    start_test();
    t = cyc;
    p = t + DB + 2;
    pb[0] = 1'b1;
    push_ev(p, 0, 0);
    push_ev(p + LC, 0, 1);
    wait_until(t + LC);
    pb[0] = 1'b0;
    wait_until(p + LC);
    vectors++;
    if (rel[0] !== 1'b1 || lp[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL priority_same_cycle: release=%b long_press=%b, required release=1 long_press=0",
               rel[0], lp[0]);
    end
    t2 = t + LC + 80;
    wait_until(t2);
    pb[0] = 1'b1;
    push_ev(t2 + DB + 2, 0, 0);
    push_ev(t2 + DB + 2 + LC, 0, 2);
    push_ev(t2 + LC + 80 + DB + 2, 0, 1);
    wait_until(t2 + LC + 80);
    pb[0] = 1'b0;
    wait_until(t2 + LC + 150);
    foreach (exp_q[i]) begin
      int idx = -1;
      foreach (obs_q[j]) if (idx < 0 && obs_q[j] == exp_q[i]) idx = j;
      vectors++;
      if (idx < 0) begin
        miscompares++;
        $display("FAIL priority_event: cyc=%0d ch=%0d kind=%0d got no pulse, required pulse",
                 exp_q[i]/64, (exp_q[i]/8)%8, exp_q[i]%8);
      end else obs_q.delete(idx);
    end
    vectors++;
    if (obs_q.size() != 0) begin
      miscompares++;
      $display("FAIL priority_extra: got %0d unexpected pulses (first cyc=%0d ch=%0d kind=%0d), required 0",
               obs_q.size(), obs_q[0]/64, (obs_q[0]/8)%8, obs_q[0]%8);
    end
  endtask

  task automatic test_independence_reset();
    int t, r;
    start_test();
    ren[0] = 1'b1;
    ren[3] = 1'b0;
    t = cyc;
    pb[0] = 1'b1;
    push_ev(t + DB + 2, 0, 0);
    push_ev(t + DB + 2 + LC, 0, 2);
    push_ev(t + DB + 2 + LC + RC, 0, 3);
    push_ev(t + 300 + DB + 2, 3, 0);
    push_ev(t + 300 + DB + 2 + LC, 3, 2);
    wait_until(t + 300);
    pb[3] = 1'b1;
    wait_until(t + 1400);
    vectors++;
    if (level !== 4'b1001) begin
      miscompares++;
      $display("FAIL indep_level: level=%b, required 1001", level);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({level, press, rel, lp, rep, anyp} !== '0) begin
      miscompares++;
      $display("FAIL midreset_outputs: got %b, required all 0", {level, press, rel, lp, rep, anyp});
    end
    repeat (3) @(negedge clk);
    r = cyc;
    rst_n = 1'b1;
    push_ev(r + DB + 2, 0, 0);
    push_ev(r + DB + 2, 3, 0);
    push_ev(r + 100 + DB + 2, 0, 1);
    push_ev(r + 100 + DB + 2, 3, 1);
    wait_until(r + DB + 1);
    vectors++;
    if (level !== 4'b0000) begin
      miscompares++;
      $display("FAIL midreset_early_level: level=%b, required 0000", level);
    end
    wait_until(r + 100);
    pb = '0;
    wait_until(r + 160);
    ren = '0;
    foreach (exp_q[i]) begin
      int idx = -1;
      foreach (obs_q[j]) if (idx < 0 && obs_q[j] == exp_q[i]) idx = j;
      vectors++;
      if (idx < 0) begin
        miscompares++;
        $display("FAIL indep_event: cyc=%0d ch=%0d kind=%0d got no pulse, required pulse",
                 exp_q[i]/64, (exp_q[i]/8)%8, exp_q[i]%8);
      end else obs_q.delete(idx);
    end
    vectors++;
    if (obs_q.size() != 0) begin
      miscompares++;
      $display("FAIL indep_extra: got %0d unexpected pulses (first cyc=%0d ch=%0d kind=%0d), required 0",
               obs_q.size(), obs_q[0]/64, (obs_q[0]/8)%8, obs_q[0]%8);
    end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_long_repeat();
    test_repeat_gating();
    test_priority();
    test_independence_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
